// File: rtl/cd_tx_sched.sv
// Two-slot frame transmit scheduler: round-robin slot grant, optional break
// character, buffer fetch, byte streaming with trailing 16-bit CRC, and
// collision retry / bit-error / cancel handling toward a serializer.
module cd_tx_sched (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [7:0]  len0,
  input  logic [7:0]  len1,
  input  logic        cfg_break,
  input  logic [3:0]  max_retry,
  input  logic        cancel,
  output logic        rd_sel,
  output logic [7:0]  rd_addr,
  input  logic [7:0]  rd_data,
  output logic [7:0]  data,
  output logic        has_data,
  input  logic        ack_data,
  output logic        is_crc_byte,
  output logic        is_last_byte,
  input  logic [15:0] crc_data,
  output logic        has_break,
  input  logic        ack_break,
  input  logic        cd,
  input  logic        err,
  output logic        abort,
  output logic [1:0]  done,
  output logic [1:0]  fail,
  output logic        busy
);

  localparam int unsigned LEN_W   = 8;
  localparam int unsigned RETRY_W = 4;

  typedef enum logic [2:0] {
    IDLE, BRK, FETCH, SEND, CRC_L, CRC_H, FIN
  } state_t;

  state_t             state_q, state_d;
  logic               sel_q, sel_d;
  logic               last_grant_q, last_grant_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]   data_q, data_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [1:0]         ld_q, ld_d;        // buffer read pipeline: 1 = addr issued, 2 = data arriving
  logic               has_data_q, has_data_d;
  logic               has_break_q, has_break_d;
  logic               crc_q, crc_d;
  logic               last_q, last_d;
  logic               abort_q, abort_d;
  logic [1:0]         done_q, done_d;
  logic [1:0]         fail_q, fail_d;
  logic               busy_q, busy_d;
  logic               gnt;
  logic [LEN_W-1:0]   gnt_len;
  logic [1:0]         sel_mask;
  logic               coll_state;

  // Next-state and registered-output computation
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    len_d        = len_q;
    addr_d       = addr_q;
    data_d       = data_q;
    retry_d      = retry_q;
    ld_d         = ld_q;
    has_data_d   = has_data_q;
    has_break_d  = has_break_q;
    crc_d        = crc_q;
    last_d       = last_q;
    abort_d      = 1'b0;
    done_d       = 2'b00;
    fail_d       = 2'b00;
    gnt          = (req == 2'b11) ? ~last_grant_q : req[1];
    gnt_len      = gnt ? len1 : len0;
    sel_mask     = sel_q ? 2'b10 : 2'b01;
    coll_state   = (state_q == BRK) || (state_q == SEND) ||
                   (state_q == CRC_L) || (state_q == CRC_H);

    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          sel_d   = gnt;
          len_d   = gnt_len;
          retry_d = '0;
          addr_d  = '0;
          if (gnt_len == '0) begin
            fail_d  = gnt ? 2'b10 : 2'b01;
            state_d = FIN;
          end else if (cfg_break) begin
            has_break_d = 1'b1;
            state_d     = BRK;
          end else begin
            ld_d    = 2'd1;
            state_d = FETCH;
          end
        end
      end
      FIN: begin
        last_grant_d = sel_q;
        state_d      = IDLE;
      end
      default: begin
        if (cancel || (coll_state && (cd || err))) begin
          has_data_d  = 1'b0;
          has_break_d = 1'b0;
          crc_d       = 1'b0;
          last_d      = 1'b0;
          ld_d        = 2'd0;
        end
        if (cancel) begin
          abort_d = 1'b1;
          fail_d  = sel_mask;
          state_d = FIN;
        end else if (coll_state && err) begin
          fail_d  = sel_mask;
          state_d = FIN;
        end else if (coll_state && cd) begin
          if (retry_q == max_retry) begin
            fail_d  = sel_mask;
            state_d = FIN;
          end else begin
            if (retry_q != '1) retry_d = retry_q + RETRY_W'(1);
            addr_d = '0;
            if (cfg_break) begin
              has_break_d = 1'b1;
              state_d     = BRK;
            end else begin
              ld_d    = 2'd1;
              state_d = FETCH;
            end
          end
        end else begin
          case (state_q)
            BRK: begin
              if (ack_break) begin
                has_break_d = 1'b0;
                ld_d        = 2'd1;
                state_d     = FETCH;
              end
            end
            FETCH: begin
              if (ld_q == 2'd2) begin
                data_d     = rd_data;
                has_data_d = 1'b1;
                ld_d       = 2'd0;
                state_d    = SEND;
              end else begin
                ld_d = 2'd2;
              end
            end
            SEND: begin
              if (ld_q == 2'd1) begin
                ld_d = 2'd2;
              end else if (ld_q == 2'd2) begin
                data_d = rd_data;
                ld_d   = 2'd0;
              end else if (ack_data) begin
                if (addr_q == len_q - LEN_W'(1)) begin
                  data_d  = crc_data[7:0];
                  crc_d   = 1'b1;
                  state_d = CRC_L;
                end else begin
                  addr_d = addr_q + LEN_W'(1);
                  ld_d   = 2'd1;
                end
              end
            end
            CRC_L: begin
              if (ack_data) begin
                data_d  = crc_data[15:8];
                last_d  = 1'b1;
                state_d = CRC_H;
              end
            end
            CRC_H: begin
              if (ack_data) begin
                has_data_d = 1'b0;
                crc_d      = 1'b0;
                last_d     = 1'b0;
                done_d     = sel_mask;
                state_d    = FIN;
              end
            end
            default: state_d = IDLE;
          endcase
        end
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      sel_q        <= 1'b0;
      last_grant_q <= 1'b1;
      len_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      retry_q      <= '0;
      ld_q         <= 2'd0;
      has_data_q   <= 1'b0;
      has_break_q  <= 1'b0;
      crc_q        <= 1'b0;
      last_q       <= 1'b0;
      abort_q      <= 1'b0;
      done_q       <= 2'b00;
      fail_q       <= 2'b00;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
      len_q        <= len_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      retry_q      <= retry_d;
      ld_q         <= ld_d;
      has_data_q   <= has_data_d;
      has_break_q  <= has_break_d;
      crc_q        <= crc_d;
      last_q       <= last_d;
      abort_q      <= abort_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      busy_q       <= busy_d;
    end
  end

  assign rd_sel       = sel_q;
  assign rd_addr      = addr_q;
  assign data         = data_q;
  assign has_data     = has_data_q;
  assign has_break    = has_break_q;
  assign is_crc_byte  = crc_q;
  assign is_last_byte = last_q;
  assign abort        = abort_q;
  assign done         = done_q;
  assign fail         = fail_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_cd_tx_sched.sv
// Bench for cd_tx_sched: buffer memory model, serializer model that records
// every consumed byte, and a per-test scoreboard of expected bytes.
`timescale 1ns/1ps
module tb_cd_tx_sched;

  typedef struct packed { logic [7:0] d; logic c; logic l; } byte_t;

  localparam int W_DATA = 0, W_BRK = 1, W_DONE = 2, W_FAIL = 3, W_CRC = 4, W_IDLE = 5;

  logic        clk = 1'b0;
  logic        reset, cfg_break, cancel, ack_data, ack_break, cd, err;
  logic [1:0]  req, done, fail;
  logic [7:0]  len0, len1, rd_addr, rd_data, data;
  logic [3:0]  max_retry;
  logic [15:0] crc_data;
  logic        rd_sel, has_data, is_crc_byte, is_last_byte, has_break, abort, busy;

  logic [7:0]  mem0 [256];
  logic [7:0]  mem1 [256];
  byte_t       exp_q [$];
  byte_t       got_q [$];
  logic        ser_en;
  int          gap, brk_cnt;
  int          n_tests = 0, n_fail = 0;
  int          d0 = 0, d1 = 0, f0 = 0, f1 = 0, hd_cyc = 0, hb_cyc = 0, ovl_cyc = 0, both_cyc = 0;

  cd_tx_sched dut (
    .clk(clk), .reset(reset), .req(req), .len0(len0), .len1(len1),
    .cfg_break(cfg_break), .max_retry(max_retry), .cancel(cancel),
    .rd_sel(rd_sel), .rd_addr(rd_addr), .rd_data(rd_data),
    .data(data), .has_data(has_data), .ack_data(ack_data),
    .is_crc_byte(is_crc_byte), .is_last_byte(is_last_byte), .crc_data(crc_data),
    .has_break(has_break), .ack_break(ack_break), .cd(cd), .err(err),
    .abort(abort), .done(done), .fail(fail), .busy(busy)
  );

  always #5 clk = ~clk;

  // Registered buffer read: data valid one clock after address
  always @(posedge clk) rd_data <= rd_sel ? mem1[rd_addr] : mem0[rd_addr];

  // Pulse and activity counters
  always @(posedge clk) begin
    if (done[0]) d0 <= d0 + 1;
    if (done[1]) d1 <= d1 + 1;
    if (fail[0]) f0 <= f0 + 1;
    if (fail[1]) f1 <= f1 + 1;
    if (has_data) hd_cyc <= hd_cyc + 1;
    if (has_break) hb_cyc <= hb_cyc + 1;
    if (has_data && has_break) ovl_cyc <= ovl_cyc + 1;
    if ((done != 2'b00 && fail != 2'b00) || done == 2'b11 || fail == 2'b11) both_cyc <= both_cyc + 1;
  end

  // Serializer model: consumes bytes with a settle gap, acks breaks at once
  initial begin : serializer
    ack_data = 1'b0; ack_break = 1'b0; gap = 0; brk_cnt = 0;
    forever begin
      @(negedge clk);
      ack_data = 1'b0; ack_break = 1'b0;
      if (gap != 0) gap--;
      else if (ser_en && has_data) begin
        got_q.push_back(byte_t'({data, is_crc_byte, is_last_byte}));
        ack_data = 1'b1;
        gap = 3;
      end
      if (has_break) begin
        ack_break = 1'b1;
        brk_cnt++;
      end
    end
  end

  task automatic wait_cond(input int which, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      case (which)
        W_DATA:  ok = has_data;
        W_BRK:   ok = has_break;
        W_DONE:  ok = (done != 2'b00);
        W_FAIL:  ok = (fail != 2'b00);
        W_CRC:   ok = is_crc_byte;
        default: ok = !busy;
      endcase
      if (ok) break;
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic c, input logic l);
    exp_q.push_back(byte_t'({d, c, l}));
  endtask

  task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1, input int n);
    push_exp(b0, 1'b0, 1'b0);
    if (n > 1) push_exp(b1, 1'b0, 1'b0);
    push_exp(crc_data[7:0], 1'b1, 1'b0);
    push_exp(crc_data[15:8], 1'b1, 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 2'b00; cancel = 1'b0; cd = 1'b0; err = 1'b0; ser_en = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({busy, has_data, has_break, is_crc_byte, is_last_byte, abort, done, fail, rd_sel, rd_addr, data} !== 28'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", {busy, has_data, has_break, is_crc_byte, is_last_byte, abort, done, fail, rd_sel, rd_addr, data});
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    bit ok; int base, ds;
    do_reset();
    mem0[0] = 8'h11; mem0[1] = 8'h22; mem0[2] = 8'h33; len0 = 8'd3; crc_data = 16'hBEEF;
    push_exp(8'h11, 1'b0, 1'b0); push_exp(8'h22, 1'b0, 1'b0); push_exp(8'h33, 1'b0, 1'b0);
    push_exp(8'hEF, 1'b1, 1'b0); push_exp(8'hBE, 1'b1, 1'b1);
    base = got_q.size(); ds = d0; ser_en = 1'b1; req = 2'b01;
    wait_cond(W_DONE, ok);
    n_tests++;
    if (!ok || done !== 2'b01 || fail !== 2'b00) begin
      n_fail++; $display("FAIL single_done: done=%b fail=%b ok=%0d required done=01", done, fail, ok);
    end
    req = 2'b00;
    wait_cond(W_IDLE, ok);
    n_tests++;
    if (d0 - ds !== 1 || got_q.size() - base !== exp_q.size()) begin
      n_fail++; $display("FAIL single_count: done pulses=%0d bytes=%0d required 1 and %0d", d0 - ds, got_q.size() - base, exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && base + k < got_q.size(); k++) begin
      n_tests++;
      if (got_q[base + k] !== exp_q[k]) begin
        n_fail++; $display("FAIL single_byte%0d: got %h required %h", k, got_q[base + k], exp_q[k]);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_round_robin();
    bit ok; int base;
    do_reset();
    len0 = 8'd1; len1 = 8'd1; mem0[0] = 8'hA0; mem1[0] = 8'hB1; crc_data = 16'h1234;
    base = got_q.size(); ser_en = 1'b1;
    for (int r = 0; r < 2; r++) begin
      push_frame(8'hA0, 8'h00, 1); push_frame(8'hB1, 8'h00, 1);
      req = 2'b11;
      wait_cond(W_DONE, ok);
      n_tests++;
      if (!ok || done !== 2'b01) begin
        n_fail++; $display("FAIL rr_first_r%0d: done=%b required 01", r, done);
      end
      req = 2'b10;
      wait_cond(W_DONE, ok);
      n_tests++;
      if (!ok || done !== 2'b10) begin
        n_fail++; $display("FAIL rr_second_r%0d: done=%b required 10", r, done);
      end
      req = 2'b00;
      wait_cond(W_IDLE, ok);
    end
    n_tests++;
    if (got_q.size() - base !== exp_q.size()) begin
      n_fail++; $display("FAIL rr_count: bytes=%0d required %0d", got_q.size() - base, exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && base + k < got_q.size(); k++) begin
      n_tests++;
      if (got_q[base + k] !== exp_q[k]) begin
        n_fail++; $display("FAIL rr_byte%0d: got %h required %h", k, got_q[base + k], exp_q[k]);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_retry();
    bit ok; int ds, fs;
    do_reset();
    max_retry = 4'd2; len0 = 8'd2; mem0[0] = 8'h5A; mem0[1] = 8'h6B; cfg_break = 1'b0;
    ds = d0; fs = f0; req = 2'b01;
    for (int a = 0; a < 3; a++) begin
      wait_cond(W_DATA, ok);
      n_tests++;
      if (!ok || rd_addr !== 8'd0 || data !== 8'h5A) begin
        n_fail++; $display("FAIL retry_attempt%0d: addr=%h data=%h ok=%0d required 00/5a", a, rd_addr, data, ok);
      end
      cd = 1'b1;
      @(negedge clk);
      cd = 1'b0;
      n_tests++;
      if (fail !== ((a == 2) ? 2'b01 : 2'b00) || done !== 2'b00) begin
        n_fail++; $display("FAIL retry_fail%0d: fail=%b done=%b", a, fail, done);
      end
    end
    req = 2'b00;
    wait_cond(W_IDLE, ok);
    n_tests++;
    if (!ok || d0 - ds !== 0 || f0 - fs !== 1) begin
      n_fail++; $display("FAIL retry_pulses: done=%0d fail=%0d required 0 and 1", d0 - ds, f0 - fs);
    end
  endtask

  task automatic test_break();
    bit ok; int base, bs, os;
    do_reset();
    cfg_break = 1'b1; max_retry = 4'd1; len0 = 8'd2; mem0[0] = 8'h5A; mem0[1] = 8'h6B; crc_data = 16'hC0DE;
    bs = brk_cnt; os = ovl_cyc; req = 2'b01;
    wait_cond(W_BRK, ok);
    n_tests++;
    if (!ok || has_data !== 1'b0) begin
      n_fail++; $display("FAIL break_first: has_break ok=%0d has_data=%b required break without data", ok, has_data);
    end
    wait_cond(W_DATA, ok);
    n_tests++;
    if (!ok || brk_cnt - bs !== 1) begin
      n_fail++; $display("FAIL break_before_data: breaks=%0d required 1", brk_cnt - bs);
    end
    cd = 1'b1;
    @(negedge clk);
    cd = 1'b0;
    n_tests++;
    if (has_break !== 1'b1 || has_data !== 1'b0) begin
      n_fail++; $display("FAIL break_retry: has_break=%b has_data=%b required 1/0", has_break, has_data);
    end
    push_frame(8'h5A, 8'h6B, 2);
    base = got_q.size(); ser_en = 1'b1;
    wait_cond(W_DONE, ok);
    n_tests++;
    if (!ok || done !== 2'b01 || brk_cnt - bs !== 2 || ovl_cyc != os) begin
      n_fail++; $display("FAIL break_done: done=%b breaks=%0d overlap=%0d required 01/2/0", done, brk_cnt - bs, ovl_cyc - os);
    end
    req = 2'b00; cfg_break = 1'b0;
    wait_cond(W_IDLE, ok);
    for (int k = 0; k < exp_q.size(); k++) begin
      n_tests++;
      if (base + k >= got_q.size() || got_q[base + k] !== exp_q[k]) begin
        n_fail++; $display("FAIL break_byte%0d: got count %0d required %h", k, got_q.size() - base, exp_q[k]);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_cancel();
    bit ok; int base;
    do_reset();
    len0 = 8'd1; mem0[0] = 8'h77; crc_data = 16'h5AA5;
    push_exp(8'h77, 1'b0, 1'b0);
    base = got_q.size(); ser_en = 1'b1; req = 2'b01;
    wait_cond(W_CRC, ok);
    ser_en = 1'b0; cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0; req = 2'b00;
    n_tests++;
    if (!ok || abort !== 1'b1 || fail !== 2'b01 || done !== 2'b00) begin
      n_fail++; $display("FAIL cancel_pulse: abort=%b fail=%b done=%b required 1/01/00", abort, fail, done);
    end
    n_tests++;
    if (has_data !== 1'b0 || is_crc_byte !== 1'b0) begin
      n_fail++; $display("FAIL cancel_clear: has_data=%b is_crc=%b required 0", has_data, is_crc_byte);
    end
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || abort !== 1'b0 || got_q.size() - base !== 1) begin
      n_fail++; $display("FAIL cancel_idle: busy=%b abort=%b bytes=%0d required 0/0/1", busy, abort, got_q.size() - base);
    end
    exp_q.delete();
  endtask

  task automatic test_err();
    bit ok; int fs;
    do_reset();
    max_retry = 4'd3; len0 = 8'd2; mem0[0] = 8'h3C; fs = f0; req = 2'b01;
    wait_cond(W_DATA, ok);
    cd = 1'b1; err = 1'b1;
    @(negedge clk);
    cd = 1'b0; err = 1'b0; req = 2'b00;
    n_tests++;
    if (!ok || fail !== 2'b01 || has_data !== 1'b0) begin
      n_fail++; $display("FAIL err_fail: fail=%b has_data=%b required 01/0", fail, has_data);
    end
    repeat (4) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || has_data !== 1'b0 || f0 - fs !== 1) begin
      n_fail++; $display("FAIL err_noretry: busy=%b has_data=%b fails=%0d required 0/0/1", busy, has_data, f0 - fs);
    end
  endtask

  task automatic test_len_zero();
    bit ok; int hs, bs, ds;
    do_reset();
    len1 = 8'd0; hs = hd_cyc; bs = hb_cyc; ds = d1; req = 2'b10;
    wait_cond(W_FAIL, ok);
    n_tests++;
    if (!ok || fail !== 2'b10 || done !== 2'b00) begin
      n_fail++; $display("FAIL len0_fail: fail=%b done=%b required 10/00", fail, done);
    end
    req = 2'b00;
    wait_cond(W_IDLE, ok);
    @(negedge clk);
    n_tests++;
    if (!ok || hd_cyc != hs || hb_cyc != bs || d1 != ds) begin
      n_fail++; $display("FAIL len0_quiet: data_cyc=%0d break_cyc=%0d done=%0d required 0", hd_cyc - hs, hb_cyc - bs, d1 - ds);
    end
  endtask

  task automatic test_reset_mid();
    bit ok; int ps;
    do_reset();
    len0 = 8'd3; mem0[0] = 8'h99; req = 2'b01;
    wait_cond(W_DATA, ok);
    ps = d0 + d1 + f0 + f1;
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (!ok || has_data !== 1'b0 || busy !== 1'b0 || done !== 2'b00 || fail !== 2'b00) begin
      n_fail++; $display("FAIL reset_mid: has_data=%b busy=%b done=%b fail=%b required 0", has_data, busy, done, fail);
    end
    reset = 1'b0; req = 2'b00;
    repeat (3) @(negedge clk);
    n_tests++;
    if (d0 + d1 + f0 + f1 != ps) begin
      n_fail++; $display("FAIL reset_mid_pulses: pulses=%0d required 0", d0 + d1 + f0 + f1 - ps);
    end
  endtask

  initial begin
    reset = 1'b1; req = 2'b00; len0 = 8'd0; len1 = 8'd0; cfg_break = 1'b0; max_retry = 4'd0;
    cancel = 1'b0; cd = 1'b0; err = 1'b0; crc_data = 16'h0000; ser_en = 1'b0;
    for (int i = 0; i < 256; i++) begin mem0[i] = 8'(i); mem1[i] = 8'(255 - i); end
    test_reset();
    test_single();
    test_round_robin();
    test_retry();
    test_break();
    test_cancel();
    test_err();
    test_len_zero();
    test_reset_mid();
    n_tests++;
    if (both_cyc != 0) begin
      n_fail++; $display("FAIL pulse_exclusive: cycles=%0d required 0", both_cyc);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cd_tx_sched.md
CD_TX_SCHED -- requirements
Module: cd_tx_sched

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
 clk  in  1  single clock; all logic on rising edge
 reset  in  1  synchronous, active-high reset
 req  in  2  per-slot frame request; level, held until done/fail for that slot
 len0, len1  in  8  slot payload length in bytes; 0 = invalid
 cfg_break  in  1  send one break character before every frame attempt
 max_retry  in  4  retries allowed after collision
 cancel  in  1  abort current frame
 rd_sel  out  1  slot whose buffer is read
 rd_addr  out  8  buffer byte address
 rd_data  in  8  buffer data, valid 1 clk after rd_sel/rd_addr
 data  out  8  byte to serializer
 has_data  out  1  data valid to serializer
 ack_data  in  1  1-clk pulse: serializer consumed data
 is_crc_byte  out  1  current byte is a CRC byte
 is_last_byte  out  1  current byte is the final byte of the frame
 crc_data  in  16  running CRC from serializer
 has_break  out  1  break request to serializer
 ack_break  in  1  1-clk pulse: break sent
 cd, err  in  1  1-clk collision / bit-error pulses from serializer
 abort  out  1  1-clk abort pulse to serializer
 done, fail  out  2  per-slot 1-clk completion / failure pulses
 busy  out  1  high whenever state != IDLE

Function
REQ-002 SHALL implement states IDLE, BRK, FETCH, SEND, CRC_L, CRC_H, FIN.
REQ-003 In IDLE, grant SHALL be round-robin: one slot requesting -> that slot; both -> slot != last_grant; last_grant resets to 1, so slot 0 wins first.
REQ-004 On grant: latch slot into rd_sel, latch its len, clear retry_cnt; go to BRK if cfg_break else FETCH.
REQ-005 Granted len == 0 SHALL pulse fail[slot], go to FIN, assert no serializer output.
REQ-006 BRK SHALL hold has_break=1 until ack_break, then deassert it and go to FETCH.
REQ-007 FETCH SHALL drive rd_addr=0, wait one clk, load data<=rd_data, set has_data=1, go to SEND.
REQ-008 In SEND, has_data SHALL stay high between bytes. On ack_data with rd_addr < len-1: increment rd_addr, load new data exactly 2 clk after ack_data.
REQ-009 On ack_data with rd_addr == len-1: load data<=crc_data[7:0], set is_crc_byte=1, go to CRC_L.
REQ-010 In CRC_L, on ack_data: load data<=crc_data[15:8], set is_last_byte=1, go to CRC_H.
REQ-011 In CRC_H, on ack_data: clear has_data, is_crc_byte, is_last_byte; pulse done[rd_sel]; go to FIN.
REQ-012 On cd in BRK/SEND/CRC_L/CRC_H: clear has_data, has_break, is_crc_byte, is_last_byte. If retry_cnt == max_retry, pulse fail and go to FIN; else increment retry_cnt and restart at BRK/FETCH per cfg_break with rd_addr=0.
REQ-013 On err in the same states: clear outputs as in REQ-012, pulse fail, go to FIN; no retry.
REQ-014 cancel in any non-IDLE, non-FIN state SHALL pulse abort, pulse fail[rd_sel], clear serializer outputs, and go to FIN. cancel SHALL have priority over cd/err/ack in the same clk.
REQ-015 cd and err in the same clk SHALL be treated as err.
REQ-016 FIN SHALL last exactly 1 clk, update last_grant=rd_sel, return to IDLE; requests are not sampled during FIN.
REQ-017 done and fail SHALL never both pulse for one frame; at most one bit of each asserted per clk.
REQ-018 retry_cnt SHALL be 4 bits and SHALL saturate, never wrap.

Reset
REQ-019 Synchronous reset SHALL force IDLE, last_grant=1, retry_cnt=0, and all outputs to 0, including done, fail, abort, has_data, has_break, is_crc_byte, is_last_byte, data, rd_addr, rd_sel, busy.
REQ-020 Reset mid-frame SHALL drop has_data the next clk with no done/fail pulse.

Verification
REQ-021 req=01, len0=3, cfg_break=0, serializer model acks -> bytes buf0[0..2], crc[7:0], crc[15:8]; is_last_byte only on last; done=01 once.
REQ-022 req=11 held, both len=1 -> slot 0 completes, then slot 1; next req=11 after both done -> slot 0 first again.
REQ-023 max_retry=2, cd injected on every attempt -> 3 attempts each from rd_addr 0, then fail pulse on that slot, no done.
REQ-024 cfg_break=1, len0=2 -> has_break until ack_break before each attempt, including after a cd retry.
REQ-025 cancel during CRC_L -> abort=1 and fail=01 in the same clk, has_data=0 next clk, then IDLE.
REQ-026 len1=0 with req=10 -> fail=10 pulse, has_data/has_break never asserted.
